// File: rtl/wb_sram_target_pkg.sv
// ---------------------------------------------------------------------------
// wb_sram_target_pkg
//   Shared definitions for the Wishbone SRAM target.
//   - WB_SRAM_LANES(dw): number of byte lanes on a dw-bit data bus.
//   - wb_state_e: response FSM encoding (also visible on the debug port).
//   - WS_CNT_W: width of the wait-state counter (covers 0..15 wait states).
// ---------------------------------------------------------------------------
`ifndef WB_SRAM_TARGET_PKG_SV
`define WB_SRAM_TARGET_PKG_SV

`define WB_SRAM_LANES(dw) ((dw) / 8)

package wb_sram_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int WS_CNT_W = 4;

endpackage

`endif

// File: rtl/wb_sram_target_mem.sv
// ---------------------------------------------------------------------------
// wb_sram_target_mem
//   Single-port synchronous RAM with per-byte write enables. The read is
//   registered: rdata_o shows the word addressed at the previous rising edge.
//   On a simultaneous read and write of one word the old contents are read.
//   Contents are never reset.
// Ports:
//   clock_i  : clock
//   index_i  : word index
//   be_i     : byte write enables (one per lane, 0 = no write)
//   wdata_i  : write data
//   rdata_o  : registered read data
// ---------------------------------------------------------------------------
module wb_sram_target_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                      clock_i,
  input  logic [IDX_W-1:0]          index_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock_i) begin
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (be_i[b]) begin
        mem_q[index_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    rdata_q <= mem_q[index_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_target.sv
// ---------------------------------------------------------------------------
// wb_sram_target
//   Wishbone classic target backed by on-chip word memory. A request seen in
//   IDLE is captured, optionally delayed by WAIT_STATES cycles, and answered
//   with a single-cycle ack (or err for misaligned / out-of-window addresses).
// Ports:
//   clock_i   : clock, rising edge
//   reset_i   : asynchronous reset, active low
//   adr_i     : byte address
//   dat_w_i   : write data
//   dat_r_o   : read data (valid during ack, held afterwards, 0 on err)
//   cyc_i     : bus cycle valid
//   stb_i     : strobe
//   we_i      : write enable
//   sel_i     : byte selects
//   ack_o     : normal termination
//   err_o     : error termination
//   state_o   : current FSM state (debug)
// Handshake: a request is accepted when cyc_i & stb_i are high in IDLE; the
// target then answers exactly once with ack_o or err_o for one cycle, unless
// cyc_i drops while waiting, which abandons the request silently.
// ---------------------------------------------------------------------------
module wb_sram_target
  import wb_sram_target_pkg::*;
#(
  parameter int WB_ADDR_WIDTH   = 32,
  parameter int WB_DATA_WIDTH   = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int ADR_SPAN_BITS   = 24,
  parameter int WAIT_STATES     = 0
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [WB_ADDR_WIDTH-1:0]   adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   dat_w_i,
  output logic [WB_DATA_WIDTH-1:0]   dat_r_o,
  input  logic                       cyc_i,
  output logic                       err_o,
  input  logic [WB_DATA_WIDTH/8-1:0] sel_i,
  input  logic                       stb_i,
  output logic                       ack_o,
  input  logic                       we_i,
  output logic [1:0]                 state_o
);

  localparam int NB    = `WB_SRAM_LANES(WB_DATA_WIDTH);
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
  localparam logic [WS_CNT_W-1:0] WS_LAST =
    WS_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  wb_state_e               state_q, state_d;
  logic [WS_CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WB_DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [NB-1:0]           sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [WB_DATA_WIDTH-1:0] hold_q, hold_d;

  logic                    misaligned;
  logic                    out_of_range;
  logic [IDX_W-1:0]        ram_idx;
  logic [NB-1:0]           ram_be;
  logic [WB_DATA_WIDTH-1:0] ram_rdata;
  logic [WB_DATA_WIDTH-1:0] resp_data;

  // Bits below LSB must be zero; bits between the memory size and the window
  // span must be zero. Bits above the span are ignored. The out-of-range set
  // is empty when the memory covers the whole window.
  always_comb begin
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    for (int i = 0; i < WB_ADDR_WIDTH; i++) begin
      if (i < LSB) begin
        misaligned = misaligned | adr_i[i];
      end else if (i >= LSB + IDX_W && i < ADR_SPAN_BITS) begin
        out_of_range = out_of_range | adr_i[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          idx_d   = adr_i[LSB +: IDX_W];
          wdat_d  = dat_w_i;
          sel_d   = sel_i;
          we_d    = we_i;
          err_d   = misaligned | out_of_range;
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == WS_LAST) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // In IDLE the RAM is addressed straight from the bus so that, with no wait
  // states, the word read at the capture edge is ready in the RESP cycle.
  // While waiting, the captured index keeps the RAM output current.
  assign ram_idx = (state_q == ST_IDLE) ? adr_i[LSB +: IDX_W] : idx_q;
  assign ram_be  = (state_q == ST_RESP && we_q && !err_q) ? sel_q : '0;

  assign resp_data = err_q ? '0 : ram_rdata;
  assign hold_d    = (state_q == ST_RESP) ? resp_data : hold_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  wb_sram_target_mem #(
    .DATA_WIDTH  (WB_DATA_WIDTH),
    .DEPTH_WORDS (MEM_DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clock_i (clock_i),
    .index_i (ram_idx),
    .be_i    (ram_be),
    .wdata_i (wdat_q),
    .rdata_o (ram_rdata)
  );

  assign ack_o   = (state_q == ST_RESP) && !err_q;
  assign err_o   = (state_q == ST_RESP) && err_q;
  assign dat_r_o = (state_q == ST_RESP) ? resp_data : hold_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_wb_sram_target.sv
// ---------------------------------------------------------------------------
// tb_wb_sram_target
//   Directed bench for wb_sram_target. Instance u_ws0 runs with no wait
//   states, u_ws3 with three. Inputs change 1 time unit after a rising edge
//   and outputs are sampled at that same offset.
// ---------------------------------------------------------------------------
module tb_wb_sram_target;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance 0: WAIT_STATES = 0
  logic [31:0] a_adr, a_dat_w, a_dat_r;
  logic        a_cyc, a_stb, a_we, a_ack, a_err;
  logic [3:0]  a_sel;
  logic [1:0]  a_state;
  // Instance 1: WAIT_STATES = 3
  logic [31:0] b_adr, b_dat_w, b_dat_r;
  logic        b_cyc, b_stb, b_we, b_ack, b_err;
  logic [3:0]  b_sel;
  logic [1:0]  b_state;

  wb_sram_target u_ws0 (
    .clock_i (clk), .reset_i (rst_n), .adr_i (a_adr), .dat_w_i (a_dat_w),
    .dat_r_o (a_dat_r), .cyc_i (a_cyc), .err_o (a_err), .sel_i (a_sel),
    .stb_i (a_stb), .ack_o (a_ack), .we_i (a_we), .state_o (a_state)
  );

  wb_sram_target #(.WAIT_STATES(3)) u_ws3 (
    .clock_i (clk), .reset_i (rst_n), .adr_i (b_adr), .dat_w_i (b_dat_w),
    .dat_r_o (b_dat_r), .cyc_i (b_cyc), .err_o (b_err), .sel_i (b_sel),
    .stb_i (b_stb), .ack_o (b_ack), .we_i (b_we), .state_o (b_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (inst == 0) begin
      a_cyc = cyc; a_stb = stb; a_we = we; a_adr = adr; a_dat_w = dat; a_sel = sel;
    end else begin
      b_cyc = cyc; b_stb = stb; b_we = we; b_adr = adr; b_dat_w = dat; b_sel = sel;
    end
  endtask

  // {ack, err} of the selected instance
  function automatic logic [31:0] resp(input int inst);
    return (inst == 0) ? {30'd0, a_ack, a_err} : {30'd0, b_ack, b_err};
  endfunction

  function automatic logic [31:0] rdata(input int inst);
    return (inst == 0) ? a_dat_r : b_dat_r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer: checks no early response, returns the response
  // cycle's {ack,err} and data, then checks the response is gone next cycle.
  task automatic xfer(input int inst, input int ws, input logic wr, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output logic [31:0] rsp, output logic [31:0] rd);
    drive(inst, 1'b1, 1'b1, wr, adr, dat, sel);
    for (int k = 0; k <= ws; k++) begin
      tick();
      if (k < ws) check("no_early_resp", resp(inst), 32'd0);
    end
    rsp = resp(inst);
    rd  = rdata(inst);
    drive(inst, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    check("resp_one_cycle", resp(inst), 32'd0);
  endtask

  logic [31:0] rsp, rd;
  logic [31:0] prev_ack;

  initial begin
    // ---------------- reset ----------------
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    check("rst_a_resp", resp(0), 32'd0);
    check("rst_a_dat", a_dat_r, 32'd0);
    check("rst_a_state", {30'd0, a_state}, 32'd0);
    check("rst_b_resp", resp(1), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // ---------------- 1: basic write/read, no wait states ----------------
    xfer(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rsp, rd);
    check("t1_wr_ack", rsp, 32'd2);
    xfer(0, 0, 1'b0, 32'h10, 32'h0, 4'hF, rsp, rd);
    check("t1_rd_ack", rsp, 32'd2);
    check("t1_rd_data", rd, 32'hDEADBEEF);

    // ---------------- 2: byte lanes ----------------
    xfer(0, 0, 1'b1, 32'h20, 32'h11223344, 4'hF, rsp, rd);
    xfer(0, 0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h2, rsp, rd);
    check("t2_lane_wr_ack", rsp, 32'd2);
    xfer(0, 0, 1'b0, 32'h20, 32'h0, 4'h0, rsp, rd);
    check("t2_lane_rd", rd, 32'h1122CC44);
    check("t2_hold_after_resp", a_dat_r, 32'h1122CC44);
    xfer(0, 0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rsp, rd);
    check("t2_sel0_ack", rsp, 32'd2);
    xfer(0, 0, 1'b0, 32'h20, 32'h0, 4'hF, rsp, rd);
    check("t2_sel0_unchanged", rd, 32'h1122CC44);

    // ---------------- 3: errors and window edges ----------------
    xfer(0, 0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rsp, rd);
    xfer(0, 0, 1'b0, 32'h13, 32'h0, 4'hF, rsp, rd);
    check("t3_misaligned_err", rsp, 32'd1);
    check("t3_misaligned_dat", rd, 32'd0);
    xfer(0, 0, 1'b1, 32'h1000, 32'h55555555, 4'hF, rsp, rd);
    check("t3_oor_err", rsp, 32'd1);
    xfer(0, 0, 1'b0, 32'h0, 32'h0, 4'hF, rsp, rd);
    check("t3_no_alias_write", rd, 32'hCAFEF00D);
    xfer(0, 0, 1'b0, 32'h00FF_F000, 32'h0, 4'hF, rsp, rd);
    check("t3_oor_high_err", rsp, 32'd1);
    xfer(0, 0, 1'b0, 32'h0100_0000, 32'h0, 4'hF, rsp, rd);
    check("t3_upper_ignored_ack", rsp, 32'd2);
    check("t3_upper_ignored_dat", rd, 32'hCAFEF00D);
    xfer(0, 0, 1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, rsp, rd);
    xfer(0, 0, 1'b0, 32'hFFC, 32'h0, 4'hF, rsp, rd);
    check("t3_last_word", rd, 32'h0BADF00D);

    // ---------------- 4: wait states ----------------
    xfer(1, 3, 1'b1, 32'h40, 32'h12345678, 4'hF, rsp, rd);
    check("t4_ws_wr_ack", rsp, 32'd2);
    xfer(1, 3, 1'b0, 32'h40, 32'h0, 4'hF, rsp, rd);
    check("t4_ws_rd_ack", rsp, 32'd2);
    check("t4_ws_rd_data", rd, 32'h12345678);
    // abort: cyc drops in the second wait cycle
    drive(1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h99999999, 4'hF);
    tick();
    check("t4_in_wait", {30'd0, b_state}, 32'd1);
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_abort_no_resp", resp(1), 32'd0);
    end
    check("t4_abort_idle", {30'd0, b_state}, 32'd0);
    xfer(1, 3, 1'b0, 32'h40, 32'h0, 4'hF, rsp, rd);
    check("t4_abort_no_write", rd, 32'h12345678);

    // ---------------- 5: back-to-back with stb held ----------------
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    prev_ack = 32'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t5_pattern", resp(0), (k % 2 == 0) ? 32'd2 : 32'd0);
      check("t5_no_repeat", prev_ack & resp(0), 32'd0);
      prev_ack = resp(0);
      if (k % 2 == 0) check("t5_data", a_dat_r, 32'hDEADBEEF);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    tick();

    // ---------------- 6: async reset during WAIT ----------------
    drive(1, 1'b1, 1'b1, 1'b1, 32'h40, 32'hBAD0BAD0, 4'hF);
    tick();
    tick();
    check("t6_pre_hold", b_dat_r, 32'h12345678);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_resp", resp(1), 32'd0);
    check("t6_async_dat", b_dat_r, 32'd0);
    check("t6_async_state", {30'd0, b_state}, 32'd0);
    check("t6_async_a_dat", a_dat_r, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    xfer(1, 3, 1'b0, 32'h40, 32'h0, 4'hF, rsp, rd);
    check("t6_after_reset_ack", rsp, 32'd2);
    check("t6_no_write", rd, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_sram_target.md
Name: wb_sram_target

Overview:
Wishbone classic (non-pipelined) target that backs a byte-addressable window with on-chip word memory. It sits on a target port of the Wishbone interconnect, downstream of address decode, and is the responder end of the bus. Response timing is registered and has a parameterised number of wait states. It raises err for misaligned or out-of-window accesses. The block is the standard memory/scratchpad endpoint for SoC bring-up and interconnect verification.

Parameters:
WB_ADDR_WIDTH, 32, address bus width.
WB_DATA_WIDTH, 32, data bus width; multiple of 8.
MEM_DEPTH_WORDS, 1024, memory depth in words; power of 2, at least 2.
ADR_SPAN_BITS, 24, low address bits forming the window offset (window 2^ADR_SPAN_BITS bytes); upper bits are ignored.
WAIT_STATES, 0, extra cycles between request sample and response; 0 to 15.

Ports:
clock  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
adr  input  WB_ADDR_WIDTH  byte address.
dat_w  input  WB_DATA_WIDTH  write data.
dat_r  output  WB_DATA_WIDTH  read data.
cyc  input  1  bus cycle valid.
err  output  1  error termination.
sel  input  WB_DATA_WIDTH/8  byte selects.
stb  input  1  strobe.
ack  output  1  normal termination.
we  input  1  write enable.

Behaviour:
- Reset (reset==0, async): ack=0, err=0, dat_r=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Derived values: LSB=log2(WB_DATA_WIDTH/8); IDX_W=log2(MEM_DEPTH_WORDS); word index=adr[LSB+:IDX_W].
- Misaligned: adr[LSB-1:0]!=0.
- Out of range: any bit of adr[ADR_SPAN_BITS-1:LSB+IDX_W] set. Check skipped if LSB+IDX_W>=ADR_SPAN_BITS.
- FSM IDLE: on cyc&stb, capture adr, dat_w, sel, we and the error flag (misaligned|out_of_range). Go to WAIT if WAIT_STATES>0, else RESP.
- FSM WAIT: counter counts up to WAIT_STATES-1, then go to RESP. If cyc==0 in any WAIT cycle, abort to IDLE with no write and no response.
- FSM RESP: drive exactly one of ack or err high for exactly one cycle, then return to IDLE.
  - Write (no error): memory updated on the edge ending the RESP cycle, only bytes with sel=1. sel=0 still acks and changes nothing.
  - Read (no error): dat_r equals mem[index] during the ack cycle; sel is ignored and the full word is returned.
  - Error: err=1, ack=0, dat_r=0, no write.
  - If cyc drops during RESP, the response still completes and the write still occurs.
- Latency: ack/err asserted WAIT_STATES+1 cycles after the cycle in which cyc&stb is first sampled in IDLE.
- ack and err deassert in the cycle after RESP, even if stb is still held. The next request is sampled from IDLE, so back-to-back transfers have a minimum period of WAIT_STATES+2 cycles.
- Outside the RESP cycle, dat_r holds its last value.
- Request inputs are ignored outside IDLE; captured values are authoritative.
- ack and err are never both 1.
- Read-after-write to the same word returns the new data.

Decomposition:
- Shared Wishbone include gets the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and a byte-lane-count helper macro.
- One sub-module, wb_sram_target_mem: single-port synchronous RAM.
  - Ports: clock, index, byte-enable write, wdata, rdata.
  - Read occurs in the cycle before RESP.
  - When WAIT_STATES==0, the read is performed at capture so dat_r is valid in RESP.

Test Plan:
1. Reset then write/read, WAIT_STATES=0: write adr=0x10, dat_w=0xDEADBEEF, sel=0xF → ack 1 cycle later. Read adr=0x10 → ack with dat_r=0xDEADBEEF, err=0 throughout.
2. Byte lanes: preload 0x11223344 at 0x20; write sel=0x2, dat_w=0xAABBCCDD → read returns 0x1122CC44. Write with sel=0 → ack, word unchanged.
3. Errors: read adr=0x13 (misaligned) → err for 1 cycle, ack=0, dat_r=0. Write adr=0x1000 (index 1024, out of range) → err, and no write aliases to index 0.
4. Wait states, WAIT_STATES=3: request at cycle N → ack at N+4 only. Drop cyc at N+2 → no ack/err, memory unchanged, next request accepted normally.
5. Back-to-back with stb held high, WAIT_STATES=0: ack pulses every 2 cycles. Verify ack and err are never asserted together, and never for 2 consecutive cycles.
6. Async reset during WAIT: assert reset low mid-transaction → ack/err/dat_r go 0 immediately without a clock edge, no write. After release, a fresh read returns the prior contents.
